// File: rtl/decay_pkg.sv
// rtl/decay_pkg.sv - shared types and constants for the decay step scheduler
package decay_pkg;

    localparam int POT_W = 32;

    localparam logic [3:0] RATE_DIV1   = 4'b0001;
    localparam logic [3:0] RATE_DIV2   = 4'b0010;
    localparam logic [3:0] RATE_DIV4   = 4'b0100;
    localparam logic [3:0] RATE_DIV8   = 4'b1000;
    localparam logic [3:0] RATE_DIV2P4 = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        ISSUE,
        WAIT_RES,
        WB,
        DONE
    } state_t;

endpackage

// File: rtl/decay_rate_regfile.sv
// rtl/decay_rate_regfile.sv - per-neuron decay-rate registers, one write port, combinational read
module decay_rate_regfile
    import decay_pkg::*;
#(
    parameter int         NUM_NEURONS  = 30,
    parameter int         ADDR_W       = 5,
    parameter logic [3:0] DEFAULT_RATE = RATE_DIV1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_rate,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        rd_rate
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

    logic [3:0] rates [NUM_NEURONS];

    // Addresses past the last neuron are silently dropped on write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                rates[i] <= DEFAULT_RATE;
            end
        end else if (we && (wr_addr <= LAST_ADDR)) begin
            rates[wr_addr] <= wr_rate;
        end
    end

    assign rd_rate = (rd_addr <= LAST_ADDR) ? rates[rd_addr] : DEFAULT_RATE;

endmodule

// File: rtl/decay_step_scheduler.sv
// rtl/decay_step_scheduler.sv - per-timestep sweep of all neurons through the shared decay unit; optional DECAY_ZERO_SKIP_EN
module decay_step_scheduler
    import decay_pkg::*;
#(
    parameter int         NUM_NEURONS  = 30,
    parameter int         ADDR_W       = 5,
    parameter logic [3:0] DEFAULT_RATE = 4'b0001
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              step_tick,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [3:0]        cfg_rate,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [POT_W-1:0]  mem_rd_data,
    output logic              mem_wr_en,
    output logic [POT_W-1:0]  mem_wr_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [POT_W-1:0]  dec_potential,
    output logic [3:0]        dec_rate,
    input  logic              dec_result_valid,
    input  logic [POT_W-1:0]  dec_result,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [POT_W-1:0]   operand_q;
    logic [POT_W-1:0]   result_q;
    logic [3:0]         rate_q;
    logic [3:0]         rf_rate;
    logic               overrun_q;
    logic               last_addr;
    logic               skip_zero;

    decay_rate_regfile #(
        .NUM_NEURONS  (NUM_NEURONS),
        .ADDR_W       (ADDR_W),
        .DEFAULT_RATE (DEFAULT_RATE)
    ) u_rate_regfile (
        .clk     (CLK),
        .rst_n   (rst_n),
        .we      (cfg_we),
        .wr_addr (cfg_addr),
        .wr_rate (cfg_rate),
        .rd_addr (addr_q),
        .rd_rate (rf_rate)
    );

    assign last_addr = (addr_q == LAST_ADDR);

`ifdef DECAY_ZERO_SKIP_EN
    assign skip_zero = (mem_rd_data[POT_W-2:0] == '0);
`else
    assign skip_zero = 1'b0;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        dec_valid = 1'b0;
        done      = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE:     if (step_tick) state_d = RD;
            RD: begin
                mem_rd_en = 1'b1;
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                if (skip_zero) state_d = last_addr ? DONE : RD;
                else           state_d = ISSUE;
            end
            ISSUE: begin
                dec_valid = 1'b1;
                if (dec_ready) state_d = WAIT_RES;
            end
            WAIT_RES: if (dec_result_valid) state_d = WB;
            WB: begin
                mem_wr_en = 1'b1;
                state_d   = last_addr ? DONE : RD;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Operand and rate are captured together so a cfg write during ISSUE cannot disturb the request.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            operand_q <= '0;
            result_q  <= '0;
            rate_q    <= DEFAULT_RATE;
            overrun_q <= 1'b0;
        end else begin
            if (step_tick && (state_q != IDLE)) overrun_q <= 1'b1;
            case (state_q)
                IDLE: if (step_tick) addr_q <= '0;
                RD_WAIT: begin
                    operand_q <= mem_rd_data;
                    rate_q    <= rf_rate;
                    if (skip_zero && !last_addr) addr_q <= addr_q + 1'b1;
                end
                WAIT_RES: if (dec_result_valid) result_q <= dec_result;
                WB: if (!last_addr) addr_q <= addr_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_addr      = addr_q;
    assign mem_wr_data   = result_q;
    assign dec_potential = operand_q;
    assign dec_rate      = rate_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_decay_step_scheduler.sv
// tb/tb_decay_step_scheduler.sv - scoreboard bench for decay_step_scheduler
module tb_decay_step_scheduler;

    localparam int N  = 30;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic          step_tick = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [3:0]    cfg_rate = 4'b0001;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data = '0;
    logic          mem_wr_en;
    logic [31:0]   mem_wr_data;
    logic          dec_valid;
    logic          dec_ready = 1'b1;
    logic [31:0]   dec_potential;
    logic [3:0]    dec_rate;
    logic          dec_result_valid = 1'b0;
    logic [31:0]   dec_result = '0;
    logic          busy;
    logic          done;
    logic          overrun;

    int n_checks = 0;
    int n_errors = 0;
    int done_count = 0;
    int bp_neuron = -1;
    int bp_cnt = 0;
    logic        bp_hold = 1'b0;
    logic [31:0] held_pot = '0;
    logic [3:0]  held_rate = '0;

    logic [31:0] mem [32];
    logic [AW-1:0] exp_addr [$];
    logic [31:0]   exp_data [$];

    decay_step_scheduler #(.NUM_NEURONS(N), .ADDR_W(AW), .DEFAULT_RATE(4'b0001)) dut (
        .CLK              (CLK),
        .rst_n            (rst_n),
        .step_tick        (step_tick),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_rate         (cfg_rate),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_rd_data      (mem_rd_data),
        .mem_wr_en        (mem_wr_en),
        .mem_wr_data      (mem_wr_data),
        .dec_valid        (dec_valid),
        .dec_ready        (dec_ready),
        .dec_potential    (dec_potential),
        .dec_rate         (dec_rate),
        .dec_result_valid (dec_result_valid),
        .dec_result       (dec_result),
        .busy             (busy),
        .done             (done),
        .overrun          (overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Power-of-two division by exponent decrement; 0011 is exact only for zero mantissa.
    function automatic logic [31:0] decay_model(input logic [31:0] p, input logic [3:0] r);
        logic [7:0] e;
        e = p[30:23];
        if (e == 8'd0) return p;
        case (r)
            4'b0010: return {p[31], e - 8'd1, p[22:0]};
            4'b0100: return {p[31], e - 8'd2, p[22:0]};
            4'b1000: return {p[31], e - 8'd3, p[22:0]};
            4'b0011: return {p[31], e - 8'd1, p[22:0] | 23'h400000};
            default: return p;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    always @(posedge CLK) begin
        dec_result_valid <= 1'b0;
        if (dec_valid && dec_ready) begin
            dec_result_valid <= 1'b1;
            dec_result       <= decay_model(dec_potential, dec_rate);
        end
    end

    always @(negedge CLK) begin
        if (bp_hold) begin
            check("bp_potential_stable", dec_potential, held_pot);
            check("bp_rate_stable", {28'd0, dec_rate}, {28'd0, held_rate});
        end
        if (dec_valid && (int'(mem_addr) == bp_neuron) && (bp_cnt < 3)) begin
            dec_ready = 1'b0;
            bp_cnt++;
        end else begin
            dec_ready = 1'b1;
        end
        bp_hold   = dec_valid && !dec_ready;
        held_pot  = dec_potential;
        held_rate = dec_rate;
    end

    always @(negedge CLK) begin : write_monitor
        logic [AW-1:0] a;
        logic [31:0]   d;
        if (rst_n && done) done_count++;
        if (rst_n && mem_wr_en) begin
            if (exp_addr.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", mem_addr, mem_wr_data);
            end else begin
                a = exp_addr.pop_front();
                d = exp_data.pop_front();
                check("wr_addr", {27'd0, mem_addr}, {27'd0, a});
                check("wr_data", mem_wr_data, d);
            end
        end
    end

    task automatic fill_mem(input logic [31:0] v);
        for (int i = 0; i < 32; i++) mem[i] = v;
    endtask

    task automatic set_rate(input int a, input logic [3:0] r);
        @(negedge CLK);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_rate = r;
        @(negedge CLK);
        cfg_we   = 1'b0;
    endtask

    task automatic push_all(input logic [31:0] v);
        for (int i = 0; i < N; i++) begin
            exp_addr.push_back(AW'(i));
            exp_data.push_back(v);
        end
    endtask

    task automatic run_sweep(input string name, input int exp_cycles, input int ovr_at);
        int cycles;
        bit seen;
        @(negedge CLK);
        step_tick = 1'b1;
        @(posedge CLK);
        #1 step_tick = 1'b0;
        cycles = 0;
        seen   = 0;
        while (!seen && cycles < 1000) begin
            @(negedge CLK);
            cycles++;
            step_tick = (cycles == ovr_at);
            if (done) seen = 1;
        end
        step_tick = 1'b0;
        check({name, "_cycles"}, cycles, exp_cycles);
        @(negedge CLK);
        check({name, "_queue_empty"}, exp_addr.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_mem_rd_en"}, {31'd0, mem_rd_en}, 0);
        check({name, "_mem_wr_en"}, {31'd0, mem_wr_en}, 0);
        check({name, "_dec_valid"}, {31'd0, dec_valid}, 0);
        check({name, "_busy"}, {31'd0, busy}, 0);
        check({name, "_done"}, {31'd0, done}, 0);
        check({name, "_overrun"}, {31'd0, overrun}, 0);
        check({name, "_mem_addr"}, {27'd0, mem_addr}, 0);
        check({name, "_mem_wr_data"}, mem_wr_data, 0);
        check({name, "_dec_potential"}, dec_potential, 0);
        check({name, "_dec_rate"}, {28'd0, dec_rate}, 32'd1);
    endtask

    initial begin
        int dc;
        fill_mem(32'h41000000);
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Abort a sweep with reset; rates revert to /1 and the next sweep starts at neuron 0.
        for (int i = 0; i < N; i++) set_rate(i, 4'b1000);
        push_all(32'h3F800000);
        @(negedge CLK);
        step_tick = 1'b1;
        @(negedge CLK);
        step_tick = 1'b0;
        repeat (37) @(negedge CLK);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        check("aborted_writes_seen", exp_addr.size(), N - 7);
        exp_addr.delete();
        exp_data.delete();
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        push_all(32'h41000000);
        run_sweep("default_rate", 151, 0);

        // Basic sweep, all /2.
        for (int i = 0; i < N; i++) set_rate(i, 4'b0010);
        fill_mem(32'h41DED852);
        push_all(32'h415ED852);
        run_sweep("basic", 151, 0);

        // Backpressure on neuron 7.
        bp_neuron = 7;
        bp_cnt    = 0;
        push_all(32'h415ED852);
        run_sweep("backpressure", 154, 0);
        check("bp_cycles_applied", bp_cnt, 3);
        bp_neuron = -1;

        // Per-neuron rates.
        set_rate(3, 4'b1000);
        set_rate(4, 4'b0011);
        set_rate(31, 4'b1000);
        fill_mem(32'h41000000);
        for (int i = 0; i < N; i++) begin
            exp_addr.push_back(AW'(i));
            exp_data.push_back(i == 3 ? 32'h3F800000 : (i == 4 ? 32'h40C00000 : 32'h40800000));
        end
        run_sweep("per_neuron", 151, 0);

        // Overrun: a tick mid-sweep is dropped and sets the sticky flag.
        check("overrun_before", {31'd0, overrun}, 0);
        set_rate(3, 4'b0010);
        set_rate(4, 4'b0010);
        push_all(32'h40800000);
        dc = done_count;
        run_sweep("overrun", 151, 20);
        repeat (5) @(negedge CLK);
        check("overrun_flag", {31'd0, overrun}, 1);
        check("overrun_done_pulses", done_count - dc, 1);
        check("overrun_idle_busy", {31'd0, busy}, 0);

        // Zero operands on neurons 0..9.
        fill_mem(32'h41DED852);
        for (int i = 0; i < 10; i++) mem[i] = 32'h00000000;
        for (int i = 0; i < N; i++) begin
`ifdef DECAY_ZERO_SKIP_EN
            if (i >= 10) begin
                exp_addr.push_back(AW'(i));
                exp_data.push_back(32'h415ED852);
            end
`else
            exp_addr.push_back(AW'(i));
            exp_data.push_back(i < 10 ? 32'h00000000 : 32'h415ED852);
`endif
        end
`ifdef DECAY_ZERO_SKIP_EN
        run_sweep("zero_skip", 121, 0);
`else
        run_sweep("zero_skip", 151, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decay_step_scheduler.md
# decay_step_scheduler

Sequences the shared floating-point potential-decay datapath across all neurons once per timestep. On each timestep tick it walks neuron addresses 0..NUM_NEURONS-1: reads the membrane potential from potential memory, hands it with that neuron's decay rate to the decay unit over a valid/ready handshake, and writes the result back. It sits between the timestep generator, the potential memory and the single decay datapath, and replaces free-running set/clear strobes with a deterministic per-neuron sequence.

## Interface
Parameters:
- NUM_NEURONS, 30, neurons swept per timestep (≥1).
- ADDR_W, 5, neuron address width; must satisfy 2^ADDR_W ≥ NUM_NEURONS.
- DEFAULT_RATE, 4'b0001, decay rate loaded into every rate register at reset (divide by 1).

Ports (clock and reset first; one clock; reset asynchronous, active-low):
- CLK  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- step_tick  in  1  one-cycle pulse that starts a sweep.
- cfg_we  in  1  write strobe for a decay-rate register.
- cfg_addr  in  ADDR_W  neuron whose rate is written.
- cfg_rate  in  4  rate code: 0001 /1, 0010 /2, 0100 /4, 1000 /8, 0011 /2+/4.
- mem_rd_en  out  1  potential memory read strobe.
- mem_addr  out  ADDR_W  read/write address.
- mem_rd_data  in  32  IEEE-754 potential, valid exactly 1 cycle after mem_rd_en.
- mem_wr_en  out  1  write-back strobe.
- mem_wr_data  out  32  decayed potential.
- dec_valid  out  1  request to decay unit.
- dec_ready  in  1  decay unit accepts the request.
- dec_potential  out  32  operand to decay unit.
- dec_rate  out  4  rate for this operand.
- dec_result_valid  in  1  one-cycle pulse with result.
- dec_result  in  32  decayed potential.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- overrun  out  1  sticky; set when step_tick arrives while busy.

## Operation
- States: IDLE, RD, RD_WAIT, ISSUE, WAIT_RES, WB, DONE.
- IDLE: on step_tick, addr←0, busy←1, go to RD.
- RD: mem_rd_en=1 for one cycle at mem_addr=addr; go to RD_WAIT.
- RD_WAIT: capture mem_rd_data into operand register; go to ISSUE.
- ISSUE: dec_valid=1 with dec_potential/dec_rate held stable until dec_valid&&dec_ready; on handshake go to WAIT_RES. Both signals remain constant while valid is high and ready is low.
- WAIT_RES: wait for dec_result_valid; latch dec_result; go to WB. A dec_result_valid outside WAIT_RES is ignored.
- WB: mem_wr_en=1, mem_wr_data=latched result, mem_addr=addr. If addr==NUM_NEURONS-1 go to DONE, else addr←addr+1, go to RD.
- DONE: done=1 for one cycle, busy←0, go to IDLE.
- Rate registers: NUM_NEURONS×4 bits. cfg_we writes on the clock edge; cfg_addr ≥ NUM_NEURONS is ignored. A write to the neuron currently in ISSUE does not change dec_rate (rate sampled in RD_WAIT).
- step_tick outside IDLE: dropped, overrun←1 (cleared only by reset). A step_tick in the DONE cycle counts as an overrun.
- Rate codes outside the five listed are passed through unchanged; the decay unit treats them as /1.

## Timing
- Reset values: mem_rd_en, mem_wr_en, dec_valid, busy, done, overrun = 0; mem_addr, mem_wr_data, dec_potential = 0; dec_rate = DEFAULT_RATE; rate registers = DEFAULT_RATE; state IDLE.
- Per neuron with dec_ready tied high and 1-cycle decay latency: RD, RD_WAIT, ISSUE, WAIT_RES, WB = 5 cycles. Full sweep = 5×NUM_NEURONS + 1 cycles from step_tick to done (151 for 30).
- Reset asserted mid-sweep aborts immediately; no partial write completes after reset; the next sweep restarts at address 0.

## Configuration
- DECAY_ZERO_SKIP_EN: when defined, an operand with bits[30:0]==0 (±0.0) skips ISSUE/WAIT_RES/WB and goes directly to the next address (2 cycles for that neuron; no memory write). When undefined, every neuron follows the full sequence.

## Structure
- Shared package decay_pkg: state enum, rate-code constants (RATE_DIV1, RATE_DIV2, RATE_DIV4, RATE_DIV8, RATE_DIV2P4), and the width constant for the potential (32).
- Natural sub-module: decay_rate_regfile (rate register array with write port and combinational read port).

## Test plan
- Reset and idle: rst_n low mid-run → every output at its reset value; the rate registers read back 0001 through dec_rate.
- Basic sweep: memory holds 32'h41DED852 at all addresses, all rates 0010, the model decay unit has 1-cycle latency → every address is written with 32'h415ED852; done pulses 151 cycles after step_tick.
- Backpressure: dec_ready low for 3 cycles on neuron 7 → dec_potential and dec_rate are stable throughout; the sweep lasts 154 cycles; results are correct.
- Per-neuron config: rate of neuron 3 set to 1000 and of neuron 4 to 0011, input 32'h41000000 (8.0) → neuron 3 gets 32'h3F800000 and neuron 4 gets 32'h40C00000.
- Overrun: step_tick at cycle 20 of a sweep → tick is ignored, overrun=1, exactly one done pulse.
- Zero skip (macro on): neurons 0..9 hold 0.0 → no mem_wr_en for those addresses, and the sweep is 30 cycles shorter; with the macro off, all 30 addresses are written.
